// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the MIPS CPU Avalon bus arbiter: arbiter state encoding and
// burst counter width.
package mips_cpu_bus_pkg;

    localparam int BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DC_READ  = 2'd1,
        IC_READ  = 2'd2,
        WB_WRITE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mips_cpu_bus_arb_prio.sv
// IDLE-state priority encoder: picks the next owner of the Avalon port and
// whether a write-buffer grant must drain the buffer completely.
module mips_cpu_bus_arb_prio
    import mips_cpu_bus_pkg::*;
(
    input  logic       wb_empty,
    input  logic       wb_full,
    input  logic       dc_read,
    input  logic       dc_addr_in_wb,
    input  logic       ic_read,
    output arb_state_t grant_state,
    output logic       grant_drain
);

    // A full buffer or a D-cache miss hitting a buffered entry forces a full drain.
    always_comb begin
        grant_state = IDLE;
        grant_drain = 1'b0;
        if (!wb_empty && (wb_full || (dc_read && dc_addr_in_wb))) begin
            grant_state = WB_WRITE;
            grant_drain = 1'b1;
        end else if (dc_read) begin
            grant_state = DC_READ;
        end else if (ic_read) begin
            grant_state = IC_READ;
        end else if (!wb_empty) begin
            grant_state = WB_WRITE;
        end else begin
            grant_state = IDLE;
        end
    end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Avalon master arbiter for I-cache misses, D-cache misses and write-buffer drain.
// Optional macro ARB_PERF_COUNTERS_EN adds perf_rd_stall/perf_drain/perf_wb_beats.
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int WB_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_read,
    input  logic [31:0] ic_addr,
    output logic        ic_waitrequest,
    input  logic        dc_read,
    input  logic [31:0] dc_addr,
    output logic        dc_waitrequest,
    input  logic        dc_addr_in_wb,
    output logic [31:0] rd_data,
    input  logic        wb_write,
    input  logic [31:0] wb_addr,
    input  logic        wb_full,
    input  logic        wb_empty,
    output logic        wb_active,
    output logic        wb_waitrequest,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
`ifdef ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_rd_stall,
    output logic [31:0] perf_drain,
    output logic [31:0] perf_wb_beats
`endif
);

    localparam logic [BURST_CNT_W-1:0] BURST_ZERO = {BURST_CNT_W{1'b0}};
    localparam logic [BURST_CNT_W-1:0] BURST_ONE  = BURST_CNT_W'(1);
    localparam logic [BURST_CNT_W-1:0] BURST_SAT  = {BURST_CNT_W{1'b1}};
    localparam logic [BURST_CNT_W-1:0] BURST_MAX  = BURST_CNT_W'(WB_BURST_MAX);

    arb_state_t             state_r;
    arb_state_t             state_s;
    arb_state_t             grant_state_s;
    logic                   grant_drain_s;
    logic [BURST_CNT_W-1:0] burst_cnt_r;
    logic [BURST_CNT_W-1:0] burst_cnt_s;
    logic [BURST_CNT_W-1:0] burst_inc_s;
    logic                   drain_r;
    logic                   drain_s;
    logic [31:0]            addr_r;
    logic [31:0]            addr_s;
    logic                   beat_s;
    logic                   read_pend_s;

    mips_cpu_bus_arb_prio u_prio (
        .wb_empty      (wb_empty),
        .wb_full       (wb_full),
        .dc_read       (dc_read),
        .dc_addr_in_wb (dc_addr_in_wb),
        .ic_read       (ic_read),
        .grant_state   (grant_state_s),
        .grant_drain   (grant_drain_s)
    );

    assign beat_s      = (state_r == WB_WRITE) && wb_write && !avm_waitrequest;
    assign read_pend_s = ic_read || dc_read;
    assign burst_inc_s = (burst_cnt_r == BURST_SAT) ? burst_cnt_r : (burst_cnt_r + BURST_ONE);

    // Next-state logic; a grant only happens from IDLE so transfers never overlap.
    always_comb begin
        state_s     = state_r;
        burst_cnt_s = burst_cnt_r;
        drain_s     = drain_r;
        addr_s      = addr_r;
        case (state_r)
            IDLE: begin
                state_s     = grant_state_s;
                drain_s     = grant_drain_s;
                burst_cnt_s = BURST_ZERO;
                case (grant_state_s)
                    DC_READ:  addr_s = dc_addr;
                    IC_READ:  addr_s = ic_addr;
                    WB_WRITE: addr_s = wb_addr;
                    default:  addr_s = addr_r;
                endcase
            end
            DC_READ, IC_READ: begin
                if (!avm_waitrequest) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            WB_WRITE: begin
                if (beat_s) begin
                    burst_cnt_s = burst_inc_s;
                end else begin
                    burst_cnt_s = burst_cnt_r;
                end
                // Yield to a waiting read once a non-drain burst reaches its limit.
                if (wb_empty || (!drain_r && read_pend_s && beat_s && (burst_inc_s == BURST_MAX))) begin
                    state_s     = IDLE;
                    burst_cnt_s = BURST_ZERO;
                    drain_s     = 1'b0;
                end else begin
                    state_s = WB_WRITE;
                end
            end
            default: begin
                state_s     = IDLE;
                burst_cnt_s = BURST_ZERO;
                drain_s     = 1'b0;
            end
        endcase
    end

    // Arbiter state registers; reset drops any bus cycle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            burst_cnt_r <= BURST_ZERO;
            drain_r     <= 1'b0;
            addr_r      <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            burst_cnt_r <= burst_cnt_s;
            drain_r     <= drain_s;
            addr_r      <= addr_s;
        end
    end

    // Bus and requester handshakes decoded from the registered state.
    always_comb begin
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = addr_r;
        wb_active      = 1'b0;
        wb_waitrequest = 1'b1;
        dc_waitrequest = 1'b1;
        ic_waitrequest = 1'b1;
        case (state_r)
            DC_READ: begin
                avm_read       = 1'b1;
                dc_waitrequest = avm_waitrequest;
            end
            IC_READ: begin
                avm_read       = 1'b1;
                ic_waitrequest = avm_waitrequest;
            end
            WB_WRITE: begin
                wb_active      = 1'b1;
                wb_waitrequest = avm_waitrequest;
                avm_write      = wb_write;
                avm_address    = wb_addr;
            end
            default: begin
                avm_read = 1'b0;
            end
        endcase
    end

    assign rd_data = avm_readdata;

`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] perf_rd_stall_r;
    logic [31:0] perf_drain_r;
    logic [31:0] perf_wb_beats_r;

    // Wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rd_stall_r <= 32'd0;
            perf_drain_r    <= 32'd0;
            perf_wb_beats_r <= 32'd0;
        end else begin
            if ((dc_read && (state_r != DC_READ)) || (ic_read && (state_r != IC_READ))) begin
                perf_rd_stall_r <= perf_rd_stall_r + 32'd1;
            end
            if ((state_r == IDLE) && (grant_state_s == WB_WRITE) && grant_drain_s) begin
                perf_drain_r <= perf_drain_r + 32'd1;
            end
            if (beat_s) begin
                perf_wb_beats_r <= perf_wb_beats_r + 32'd1;
            end
        end
    end

    assign perf_rd_stall = perf_rd_stall_r;
    assign perf_drain    = perf_drain_r;
    assign perf_wb_beats = perf_wb_beats_r;
`endif

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: memory/write-buffer/cache models around the
// arbiter, a read-response scoreboard, directed ordering scenarios and random traffic.
module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_read, dc_read, dc_addr_in_wb, wb_write, wb_full, wb_empty, avm_waitrequest;
    logic [31:0] ic_addr, dc_addr, wb_addr, avm_readdata;
    logic        ic_waitrequest, dc_waitrequest, wb_active, wb_waitrequest, avm_read, avm_write;
    logic [31:0] rd_data, avm_address;
`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] perf_rd_stall, perf_drain, perf_wb_beats;
`endif

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter #(.WB_BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ic_read(ic_read), .ic_addr(ic_addr), .ic_waitrequest(ic_waitrequest),
        .dc_read(dc_read), .dc_addr(dc_addr), .dc_waitrequest(dc_waitrequest),
        .dc_addr_in_wb(dc_addr_in_wb), .rd_data(rd_data),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_full(wb_full), .wb_empty(wb_empty),
        .wb_active(wb_active), .wb_waitrequest(wb_waitrequest),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
`ifdef ARB_PERF_COUNTERS_EN
        , .perf_rd_stall(perf_rd_stall), .perf_drain(perf_drain), .perf_wb_beats(perf_wb_beats)
`endif
    );

    localparam int WB_DEPTH = 8;

    int n_chk = 0;
    int n_pass = 0;

    // Memory as seen on the bus, and architectural memory (all writes issued so far).
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] arch [logic [31:0]];
    logic [31:0] wbq_a[$];
    logic [31:0] wbq_d[$];
    bit          dc_pend = 1'b0;
    bit          ic_pend = 1'b0;
    logic [31:0] dc_a = 32'h0;
    logic [31:0] ic_a = 32'h0;
    logic [31:0] dc_exp_a[$], dc_exp_d[$], ic_exp_a[$], ic_exp_d[$];
    bit          log_w[$];
    logic [31:0] log_a[$];
    bit          exp_w[$];
    logic [31:0] exp_a[$];
    int          stall_pct = 0;
    int          stall_left = 0;
    int          rd_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_val(a);
    endfunction

    task automatic push_wb(input logic [31:0] a, input logic [31:0] d);
        wbq_a.push_back(a);
        wbq_d.push_back(d);
        arch[a] = d;
    endtask

    task automatic issue_dc(input logic [31:0] a);
        dc_pend = 1'b1;
        dc_a    = a;
        dc_exp_a.push_back(a);
        dc_exp_d.push_back(arch_rd(a));
    endtask

    task automatic issue_ic(input logic [31:0] a);
        ic_pend = 1'b1;
        ic_a    = a;
        ic_exp_a.push_back(a);
        ic_exp_d.push_back(arch_rd(a));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((dc_pend || ic_pend || wbq_a.size() != 0 || wb_active || avm_read) && n < 3000) begin
            step();
            n++;
        end
        chk({nm, "_idle_timeout"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, 32'(log_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
            chk({nm, "_seq"}, (log_w[i] ? 32'h8000_0000 : 32'h0) | log_a[i],
                (exp_w[i] ? 32'h8000_0000 : 32'h0) | exp_a[i]);
        end
        log_w.delete(); log_a.delete(); exp_w.delete(); exp_a.delete();
    endtask

    task automatic expect_bus(input bit w, input logic [31:0] a);
        exp_w.push_back(w);
        exp_a.push_back(a);
    endtask

    // Bus-side models: drive requests/WB/slave on negedge, commit transfers before the posedge.
    initial begin
        ic_read = 1'b0; dc_read = 1'b0; dc_addr_in_wb = 1'b0; wb_write = 1'b0;
        wb_full = 1'b0; wb_empty = 1'b1; avm_waitrequest = 1'b1;
        ic_addr = 32'h0; dc_addr = 32'h0; wb_addr = 32'h0; avm_readdata = 32'h0;
        forever begin
            @(negedge clk);
            dc_read  = dc_pend;
            dc_addr  = dc_a;
            ic_read  = ic_pend;
            ic_addr  = ic_a;
            wb_empty = (wbq_a.size() == 0);
            wb_full  = (wbq_a.size() >= WB_DEPTH);
            wb_addr  = wb_empty ? 32'h0 : wbq_a[0];
            dc_addr_in_wb = 1'b0;
            foreach (wbq_a[i]) if (dc_pend && wbq_a[i] == dc_a) dc_addr_in_wb = 1'b1;
            wb_write = wb_active && !wb_empty;
            if (stall_left > 0 && avm_read) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
            end
            #1;
            avm_readdata = mem_rd(avm_address);
            #1;
            if (avm_read) rd_cycles++;
            if (avm_write && !avm_waitrequest && wbq_a.size() != 0) begin
                chk("wb_beat_addr", avm_address, wbq_a[0]);
                mem[avm_address] = wbq_d[0];
                log_w.push_back(1'b1);
                log_a.push_back(avm_address);
                void'(wbq_a.pop_front());
                void'(wbq_d.pop_front());
            end
            if (avm_read && !avm_waitrequest) begin
                log_w.push_back(1'b0);
                log_a.push_back(avm_address);
                if (!dc_waitrequest) dc_pend = 1'b0;
                if (!ic_waitrequest) ic_pend = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every completed read must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!dc_waitrequest) begin
                chk("dc_outstanding", 32'(dc_exp_d.size()), 32'd1);
                if (dc_exp_d.size() != 0) begin
                    chk("dc_addr", avm_address, dc_exp_a.pop_front());
                    chk("dc_data", rd_data, dc_exp_d.pop_front());
                end
            end
            if (!ic_waitrequest) begin
                chk("ic_outstanding", 32'(ic_exp_d.size()), 32'd1);
                if (ic_exp_d.size() != 0) begin
                    chk("ic_addr", avm_address, ic_exp_a.pop_front());
                    chk("ic_data", rd_data, ic_exp_d.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int n;
        #1;
        chk("rst_avm_read", 32'(avm_read), 32'd0);
        chk("rst_avm_write", 32'(avm_write), 32'd0);
        chk("rst_wb_active", 32'(wb_active), 32'd0);
        chk("rst_waitreqs", {29'd0, dc_waitrequest, ic_waitrequest, wb_waitrequest}, 32'd7);
        chk("rst_avm_address", avm_address, 32'h0);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single D-cache read with two stall cycles.
        mem[32'h1000] = 32'hDEAD_BEEF;
        arch[32'h1000] = 32'hDEAD_BEEF;
        stall_left = 2;
        rd_cycles = 0;
        issue_dc(32'h1000);
        expect_bus(1'b0, 32'h1000);
        wait_idle("t1");
        chk("t1_read_cycles", 32'(rd_cycles), 32'd3);
        check_log("t1");

        // Simultaneous I/D misses: D first.
        issue_ic(32'h400);
        issue_dc(32'h800);
        expect_bus(1'b0, 32'h800);
        expect_bus(1'b0, 32'h400);
        wait_idle("t2");
        check_log("t2");

        // Burst limit: 4 beats, then the read, then the rest.
        for (int i = 0; i < 6; i++) push_wb(32'h3000 + 32'(4 * i), $urandom);
        n = 0;
        while (!wb_active && n < 20) begin step(); n++; end
        chk("t3_wb_granted", 32'(wb_active), 32'd1);
        issue_dc(32'h2000);
        for (int i = 0; i < 4; i++) expect_bus(1'b1, 32'h3000 + 32'(4 * i));
        expect_bus(1'b0, 32'h2000);
        expect_bus(1'b1, 32'h3010);
        expect_bus(1'b1, 32'h3014);
        wait_idle("t3");
        check_log("t3");

        // Read-after-write hazard: full drain before the read.
        push_wb(32'h2100, $urandom);
        push_wb(32'h2104, $urandom);
        push_wb(32'h2100, $urandom);
        issue_dc(32'h2100);
        expect_bus(1'b1, 32'h2100);
        expect_bus(1'b1, 32'h2104);
        expect_bus(1'b1, 32'h2100);
        expect_bus(1'b0, 32'h2100);
        wait_idle("t4");
        check_log("t4");

        // Full WB drains completely before an I-cache read.
        for (int i = 0; i < WB_DEPTH; i++) push_wb(32'h2200 + 32'(4 * i), $urandom);
        issue_ic(32'h480);
        for (int i = 0; i < WB_DEPTH; i++) expect_bus(1'b1, 32'h2200 + 32'(4 * i));
        expect_bus(1'b0, 32'h480);
        wait_idle("t5");
        check_log("t5");

        // Reset in the middle of a stalled read.
        stall_left = 100;
        issue_dc(32'h1004);
        n = 0;
        while (!avm_read && n < 20) begin step(); n++; end
        chk("t6_read_started", 32'(avm_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_read_drop", 32'(avm_read), 32'd0);
        chk("t6_async_wb_inactive", 32'(wb_active), 32'd0);
        chk("t6_dc_waitrequest", 32'(dc_waitrequest), 32'd1);
        dc_pend = 1'b0;
        dc_exp_a.delete();
        dc_exp_d.delete();
        stall_left = 0;
        step();
        step();
        rst = 1'b0;
        step();
        log_w.delete(); log_a.delete();
        issue_dc(32'h1008);
        expect_bus(1'b0, 32'h1008);
        wait_idle("t6");
        check_log("t6");

        // Random mixed traffic against the architectural memory model.
        stall_pct = 30;
        for (int c = 0; c < 2000; c++) begin
            if (wbq_a.size() < WB_DEPTH && $urandom_range(0, 99) < 30) begin
                a = 32'h2000 + 32'(4 * $urandom_range(0, 7));
                if (!(dc_pend && a == dc_a)) push_wb(a, $urandom);
            end
            if (!dc_pend && $urandom_range(0, 99) < 20) issue_dc(32'h2000 + 32'(4 * $urandom_range(0, 7)));
            if (!ic_pend && $urandom_range(0, 99) < 20) issue_ic(32'h400 + 32'(4 * $urandom_range(0, 63)));
            step();
        end
        stall_pct = 0;
        wait_idle("rand");
        for (int i = 0; i < 8; i++) begin
            a = 32'h2000 + 32'(4 * i);
            chk("rand_mem_final", mem_rd(a), arch_rd(a));
        end
        chk("rand_dc_leftover", 32'(dc_exp_d.size()), 32'd0);
        chk("rand_ic_leftover", 32'(ic_exp_d.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
